// File: rtl/ntt_stage_scheduler_if.sv
// Handshake and array/memory control bundle between the NTT stage scheduler and its host.
// SCHED_PERF_EN adds the cycle_count observation signal.
interface ntt_stage_scheduler_if #(
  parameter int N_BATCH  = 8,
  parameter int N_STAGES = 11,
  parameter int LUT_SIZE = 1360
);
  localparam int WW = $clog2(LUT_SIZE);
  localparam int BW = (N_BATCH > 1) ? $clog2(N_BATCH) : 1;
  localparam int SW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  logic          start;
  logic          op;
  logic          swap_in;
  logic          busy;
  logic          done;
  logic          bf_mode;
  logic          bf_swap;
  logic [WW-1:0] w_idx;
  logic          rd_en;
  logic [BW-1:0] rd_addr;
  logic          wr_en;
  logic [BW-1:0] wr_addr;
  logic [SW-1:0] stage;
`ifdef SCHED_PERF_EN
  logic [15:0]   cycle_count;
`endif

  modport master (
`ifdef SCHED_PERF_EN
    input  cycle_count,
`endif
    output start, op, swap_in,
    input  busy, done, bf_mode, bf_swap, w_idx, rd_en, rd_addr, wr_en, wr_addr, stage
  );

  modport slave (
`ifdef SCHED_PERF_EN
    output cycle_count,
`endif
    input  start, op, swap_in,
    output busy, done, bf_mode, bf_swap, w_idx, rd_en, rd_addr, wr_en, wr_addr, stage
  );
endinterface

// File: rtl/ntt_stage_scheduler.sv
// Sequencer for the butterfly array: runs a full NTT or one pointwise-multiply pass.
// Optional SCHED_PERF_EN adds a saturating busy-cycle counter (cycle_count).
//
//   state | meaning
//   IDLE  | waiting for start; outputs hold, no memory traffic
//   ISSUE | one batch read per cycle, twiddle index driven to the array
//   DRAIN | PIPE_LAT quiet cycles so the stage's write-back completes
//   DONE  | one-cycle done pulse, back to IDLE
module ntt_stage_scheduler #(
  parameter int N_BATCH  = 8,
  parameter int N_STAGES = 11,
  parameter int PIPE_LAT = 6,
  parameter int LUT_SIZE = 1360,
  parameter int MUL_BASE = 1344
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  ntt_stage_scheduler_if.slave  bus_if
);

  localparam int WW = $clog2(LUT_SIZE);
  localparam int BW = (N_BATCH > 1) ? $clog2(N_BATCH) : 1;
  localparam int SW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          op_q, op_d;
  logic          swap_q, swap_d;
  logic [BW-1:0] batch_q, batch_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          mode_hold_q, mode_hold_d;
  logic          swap_hold_q, swap_hold_d;
  logic [WW-1:0] widx_hold_q, widx_hold_d;

  logic          dly_en_q   [PIPE_LAT];
  logic [BW-1:0] dly_addr_q [PIPE_LAT];

  logic          is_issue;
  logic [WW-1:0] issue_widx;

  assign is_issue = (state_q == ST_ISSUE);

  // NTT twiddles run contiguously across stages; the multiply pass uses the constant rows.
  always_comb begin
    if (op_q) begin
      issue_widx = WW'(MUL_BASE) + WW'(batch_q);
    end else begin
      issue_widx = WW'(stage_q) * WW'(N_BATCH) + WW'(batch_q);
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    swap_d      = swap_q;
    batch_d     = batch_q;
    stage_d     = stage_q;
    drain_d     = drain_q;
    mode_hold_d = mode_hold_q;
    swap_hold_d = swap_hold_q;
    widx_hold_d = widx_hold_q;
    case (state_q)
      ST_IDLE: begin
        if (bus_if.start) begin
          op_d    = bus_if.op;
          swap_d  = bus_if.swap_in;
          batch_d = '0;
          stage_d = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mode_hold_d = op_q;
        swap_hold_d = op_q & swap_q;
        widx_hold_d = issue_widx;
        if (batch_q == BW'(N_BATCH - 1)) begin
          batch_d = '0;
          drain_d = DW'(PIPE_LAT - 1);
          state_d = ST_DRAIN;
        end else begin
          batch_d = batch_q + BW'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) begin
          if (!op_q && (stage_q < SW'(N_STAGES - 1))) begin
            stage_d = stage_q + SW'(1);
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      op_q        <= 1'b0;
      swap_q      <= 1'b0;
      batch_q     <= '0;
      stage_q     <= '0;
      drain_q     <= '0;
      mode_hold_q <= 1'b0;
      swap_hold_q <= 1'b0;
      widx_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      swap_q      <= swap_d;
      batch_q     <= batch_d;
      stage_q     <= stage_d;
      drain_q     <= drain_d;
      mode_hold_q <= mode_hold_d;
      swap_hold_q <= swap_hold_d;
      widx_hold_q <= widx_hold_d;
    end
  end

  // Write-back tracks reads through the array latency regardless of FSM state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        dly_en_q[i]   <= 1'b0;
        dly_addr_q[i] <= '0;
      end
    end else begin
      dly_en_q[0]   <= is_issue;
      dly_addr_q[0] <= batch_q;
      for (int i = 1; i < PIPE_LAT; i++) begin
        dly_en_q[i]   <= dly_en_q[i-1];
        dly_addr_q[i] <= dly_addr_q[i-1];
      end
    end
  end

  assign bus_if.busy    = (state_q != ST_IDLE);
  assign bus_if.done    = (state_q == ST_DONE);
  assign bus_if.rd_en   = is_issue;
  assign bus_if.rd_addr = batch_q;
  assign bus_if.bf_mode = is_issue ? op_q : mode_hold_q;
  assign bus_if.bf_swap = is_issue ? (op_q & swap_q) : swap_hold_q;
  assign bus_if.w_idx   = is_issue ? issue_widx : widx_hold_q;
  assign bus_if.stage   = stage_q;
  assign bus_if.wr_en   = dly_en_q[PIPE_LAT-1];
  assign bus_if.wr_addr = dly_addr_q[PIPE_LAT-1];

`ifdef SCHED_PERF_EN
  logic [15:0] cyc_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_cnt_q <= '0;
    end else if ((state_q == ST_IDLE) && bus_if.start) begin
      cyc_cnt_q <= '0;
    end else if ((state_q != ST_IDLE) && (cyc_cnt_q != 16'hFFFF)) begin
      cyc_cnt_q <= cyc_cnt_q + 16'd1;
    end
  end

  assign bus_if.cycle_count = cyc_cnt_q;
`endif

endmodule
